// File: rtl/nested_record_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nested_record_pkg
//  Purpose  : Shared types and constants for the nested-record assembler
//             and its record FIFO. Holds the 8-bit header type, the header
//             width, and the default build-time dimensions. The full record
//             type depends on module parameters, so each module declares it
//             locally.
//  Revision : 1.0  initial release
// ============================================================================
package nested_record_pkg;

    localparam int HDR_W       = 8;
    localparam int DEF_FIELD_W = 8;
    localparam int DEF_NUM_CH  = 2;
    localparam int DEF_DEPTH   = 4;
    // Record width for the default dimensions (header + NUM_CH payload fields)
    localparam int REC_W       = HDR_W + DEF_NUM_CH * DEF_FIELD_W;

    // Header layout, MSB to LSB: flag, kind, seq
    typedef struct packed {
        logic       flag;
        logic [1:0] kind;
        logic [4:0] seq;
    } hdr_t;

endpackage : nested_record_pkg
`default_nettype wire

// File: rtl/record_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : record_fifo
//  Purpose  : DEPTH-entry FIFO of WIDTH-bit records with a registered head
//             output stage. o_level counts every committed record, including
//             the one currently presented on o_data.
//  Ports    : clk, rst          clock, synchronous active-high reset
//             i_push            write i_push_data (caller guarantees !o_full)
//             i_push_data       record to store
//             o_full            o_level == DEPTH
//             o_valid/i_ready   head-record handshake, pop on o_valid&&i_ready
//             o_data            registered head record
//             o_level           number of records held, 0..DEPTH
//  Revision : 1.0  initial release
// ============================================================================
module record_fifo
    import nested_record_pkg::*;
#(
    parameter int WIDTH = REC_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_push_data,
    output logic                     o_full,
    input  logic                     i_ready,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_push;
    logic             w_pop;
    logic [LW-1:0]    w_avail;
    logic [AW-1:0]    w_head;

    assign o_full  = (r_level == LW'(DEPTH));
    assign w_push  = i_push && !o_full;
    assign w_pop   = r_out_valid && i_ready;

    // Records already in storage once this edge's pop is taken into account.
    // A push on this same edge is not yet visible to the output stage, which
    // gives the one-cycle first-word latency.
    assign w_avail = r_level - LW'(w_pop);
    // On a pop the output stage must skip past the entry being consumed.
    assign w_head  = w_pop ? (r_rptr + AW'(1)) : r_rptr;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            r_level     <= r_level + LW'(w_push) - LW'(w_pop);
            r_out_valid <= (w_avail != '0);
            // Reloading the same head while stalled keeps o_data stable.
            if (w_avail != '0) begin
                r_out_data <= r_mem[w_head];
            end
        end
    end

    assign o_valid = r_out_valid;
    assign o_data  = r_out_data;
    assign o_level = r_level;

endmodule : record_fifo
`default_nettype wire

// File: rtl/nested_record_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : nested_record_fifo
//  Purpose  : Assembles FIELD_W-bit beats into a packed nested record
//             {hdr_t hdr, ch[NUM_CH-1:0]} and buffers up to DEPTH complete
//             records. Beat 0 is the header (in_data[7:0]); beats 1..NUM_CH
//             fill ch[0]..ch[NUM_CH-1]. Misplaced or missing in_last raises a
//             one-cycle err_pulse.
//  Ports    : clk, rst                   clock, synchronous active-high reset
//             in_valid/in_ready          beat handshake
//             in_data, in_last           beat payload and end-of-record mark
//             out_valid/out_ready        head-record handshake
//             out_rec                    packed record, header in MSBs,
//                                        ch[0] in LSBs
//             level                      records stored, 0..DEPTH
//             err_pulse                  framing-error pulse
//  Revision : 1.0  initial release
// ============================================================================
module nested_record_fifo
    import nested_record_pkg::*;
#(
    parameter int FIELD_W = DEF_FIELD_W,
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [FIELD_W-1:0]                in_data,
    input  logic                              in_last,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [HDR_W+NUM_CH*FIELD_W-1:0]   out_rec,
    output logic [$clog2(DEPTH):0]            level,
    output logic                              err_pulse
);

    localparam int C_REC_W = HDR_W + NUM_CH * FIELD_W;
    localparam int CNT_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(NUM_CH - 1);

    typedef struct packed {
        hdr_t                          hdr;
        logic [NUM_CH-1:0][FIELD_W-1:0] ch;
    } rec_t;

    typedef enum logic [0:0] {
        S_HDR = 1'b0,
        S_PAY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    rec_t             r_rec;
    rec_t             w_push_rec;
    logic             r_err;
    logic             w_err_nxt;

    logic             w_accept;
    logic             w_final;
    logic             w_full;
    logic             w_push;
    logic             w_hdr_we;
    logic             w_ch_we;

    // The final beat is the only one that needs a free FIFO slot, so the
    // stall is confined to it and depends only on registered state.
    assign w_final  = (r_state == S_PAY) && (r_cnt == C_CNT_LAST);
    assign in_ready = !w_final || !w_full;
    assign w_accept = in_valid && in_ready;

    // The last channel is never stored in r_rec; it is merged straight from
    // in_data into the record being pushed.
    always_comb begin
        w_push_rec               = r_rec;
        w_push_rec.ch[NUM_CH-1]  = in_data;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_push      = 1'b0;
        w_err_nxt   = 1'b0;
        w_hdr_we    = 1'b0;
        w_ch_we     = 1'b0;
        case (r_state)
            S_HDR: begin
                if (w_accept) begin
                    if (in_last) begin
                        // A one-beat record is always malformed.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_hdr_we    = 1'b1;
                        w_state_nxt = S_PAY;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            S_PAY: begin
                if (w_accept) begin
                    if (w_final) begin
                        // Complete record is kept even without in_last.
                        w_push      = 1'b1;
                        w_err_nxt   = !in_last;
                        w_state_nxt = S_HDR;
                        w_cnt_nxt   = '0;
                    end else if (in_last) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = S_HDR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_ch_we     = 1'b1;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = S_HDR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_HDR;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_rec   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_err   <= w_err_nxt;
            if (w_hdr_we) begin
                r_rec.hdr <= hdr_t'(in_data[HDR_W-1:0]);
            end
            if (w_ch_we) begin
                r_rec.ch[r_cnt] <= in_data;
            end
        end
    end

    record_fifo #(
        .WIDTH (C_REC_W),
        .DEPTH (DEPTH)
    ) u_record_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_data (w_push_rec),
        .o_full      (w_full),
        .i_ready     (out_ready),
        .o_valid     (out_valid),
        .o_data      (out_rec),
        .o_level     (level)
    );

    assign err_pulse = r_err;

endmodule : nested_record_fifo
`default_nettype wire

// File: tb/tb_nested_record_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nested_record_fifo
//  Purpose  : Self-checking bench for nested_record_fifo at default
//             dimensions. A queue-based model tracks the partial record, the
//             committed records and the expected error pulse.
//  Revision : 1.0  initial release
// ============================================================================
module tb_nested_record_fifo;

    localparam int FW     = 8;
    localparam int NUM_CH = 2;
    localparam int DEPTH  = 4;
    localparam int REC_W  = 8 + NUM_CH * FW;
    localparam int LVL_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [FW-1:0]     in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [REC_W-1:0]  out_rec;
    logic [LVL_W-1:0]  level;
    logic              err_pulse;

    nested_record_fifo #(
        .FIELD_W (FW),
        .NUM_CH  (NUM_CH),
        .DEPTH   (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_rec   (out_rec),
        .level     (level),
        .err_pulse (err_pulse)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [FW-1:0]    beats[$];
    logic [REC_W-1:0] exp_q[$];
    bit               exp_err = 1'b0;
    int               err_count = 0;

    // Result of the most recent tick's output handshake
    bit               pop_seen;
    bit               pop_exp_ok;
    logic [REC_W-1:0] pop_obs;
    logic [REC_W-1:0] pop_exp;

    // Header in the top byte, then beat NUM_CH ... beat 1 (ch[0] in LSBs).
    function automatic logic [REC_W-1:0] pack_rec();
        logic [REC_W-1:0] r = '0;
        logic [FW-1:0]    h;
        h = beats[0];
        r[REC_W-1 -: 8] = h[7:0];
        for (int i = 1; i <= NUM_CH; i++) begin
            r[(i-1)*FW +: FW] = beats[i];
        end
        return r;
    endfunction

    // One clock edge plus model update; outputs are read #1 after the edge.
    task automatic tick();
        bit            acc;
        bit            pop;
        bit            was_rst;
        logic [FW-1:0] d;
        bit            l;
        acc        = in_valid && in_ready;
        pop        = out_valid && out_ready;
        was_rst    = rst;
        d          = in_data;
        l          = in_last;
        pop_seen   = pop && !was_rst;
        pop_obs    = out_rec;
        pop_exp_ok = (exp_q.size() > 0);
        pop_exp    = pop_exp_ok ? exp_q[0] : '0;
        @(posedge clk);
        #1;
        if (was_rst) begin
            beats.delete();
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if (pop && exp_q.size() > 0) void'(exp_q.pop_front());
            exp_err = 1'b0;
            if (acc) begin
                beats.push_back(d);
                if (beats.size() == NUM_CH + 1) begin
                    exp_q.push_back(pack_rec());
                    exp_err = !l;
                    beats.delete();
                end else if (l) begin
                    exp_err = 1'b1;
                    beats.delete();
                end
            end
        end
        if (err_pulse) err_count++;
    endtask

    task automatic send_beat(input logic [FW-1:0] d, input bit l);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int w = 0; w < 20 && !in_ready; w++) tick();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL send_beat_wait: in_ready=%b required 1", in_ready);
        else n_pass++;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_record_rand(input bit good_last);
        send_beat(FW'($urandom), 1'b0);
        for (int i = 1; i <= NUM_CH; i++) begin
            send_beat(FW'($urandom), (i == NUM_CH) ? good_last : 1'b0);
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int k = 0; k < 64 && exp_q.size() != 0; k++) begin
            tick();
            if (pop_seen) begin
                n_checks++;
                if (!pop_exp_ok || pop_obs !== pop_exp)
                    $display("FAIL drain_pop: out_rec=%0h required %0h", pop_obs, pop_exp);
                else n_pass++;
            end
        end
        out_ready = 1'b0;
        tick();
        n_checks++;
        if (level !== '0 || out_valid !== 1'b0)
            $display("FAIL drain_empty: level=%0d out_valid=%b required 0/0", level, out_valid);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        tick(); tick();
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", in_ready); else n_pass++;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b required 0", out_valid); else n_pass++;
        n_checks++;
        if (out_rec !== '0) $display("FAIL reset_out_rec: got %0h required 0", out_rec); else n_pass++;
        n_checks++;
        if (level !== '0) $display("FAIL reset_level: got %0d required 0", level); else n_pass++;
        n_checks++;
        if (err_pulse !== 1'b0) $display("FAIL reset_err: got %b required 0", err_pulse); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int e0;
        logic [REC_W-1:0] want;
        e0 = err_count;
        send_beat(8'hA5, 1'b0);
        send_beat(8'h11, 1'b0);
        send_beat(8'h22, 1'b1);
        n_checks++;
        if (level !== 1 || out_valid !== 1'b0)
            $display("FAIL single_latency: level=%0d out_valid=%b required 1/0", level, out_valid);
        else n_pass++;
        tick();
        // ch[0]=0x11 sits in the LSBs, so the record packs as A5_22_11.
        want = 24'hA52211;
        n_checks++;
        if (out_valid !== 1'b1 || out_rec !== want)
            $display("FAIL single_out: out_valid=%b out_rec=%0h required 1/%0h", out_valid, out_rec, want);
        else n_pass++;
        n_checks++;
        if (err_count != e0) $display("FAIL single_err: pulses=%0d required 0", err_count - e0); else n_pass++;
        drain();
    endtask

    task automatic test_full();
        out_ready = 1'b0;
        for (int r = 0; r < DEPTH; r++) send_record_rand(1'b1);
        tick();
        n_checks++;
        if (level !== LVL_W'(DEPTH) || out_valid !== 1'b1)
            $display("FAIL full_level: level=%0d out_valid=%b required %0d/1", level, out_valid, DEPTH);
        else n_pass++;
        in_valid = 1'b1; in_last = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_data = FW'($urandom);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL full_nonfinal_ready: beat %0d in_ready=%b required 1", i, in_ready);
            else n_pass++;
            tick();
        end
        in_data = FW'($urandom); in_last = 1'b1;
        tick(); tick();
        n_checks++;
        if (in_ready !== 1'b0 || level !== LVL_W'(DEPTH))
            $display("FAIL full_stall: in_ready=%b level=%0d required 0/%0d", in_ready, level, DEPTH);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (!pop_seen || !pop_exp_ok || pop_obs !== pop_exp)
            $display("FAIL full_pop: seen=%b out_rec=%0h required %0h", pop_seen, pop_obs, pop_exp);
        else n_pass++;
        n_checks++;
        if (level !== LVL_W'(DEPTH - 1) || in_ready !== 1'b1)
            $display("FAIL full_after_pop: level=%0d in_ready=%b required %0d/1", level, in_ready, DEPTH - 1);
        else n_pass++;
        tick();
        in_valid = 1'b0; in_last = 1'b0;
        n_checks++;
        if (level !== LVL_W'(DEPTH)) $display("FAIL full_refill: level=%0d required %0d", level, DEPTH);
        else n_pass++;
        drain();
    endtask

    task automatic test_frame_err();
        logic [LVL_W-1:0] l0;
        out_ready = 1'b0;
        send_record_rand(1'b1);
        tick();
        l0 = level;
        send_beat(8'h80, 1'b0);
        send_beat(8'h33, 1'b1);
        n_checks++;
        if (err_pulse !== 1'b1 || level !== l0)
            $display("FAIL early_last: err=%b level=%0d required 1/%0d", err_pulse, level, l0);
        else n_pass++;
        tick();
        n_checks++;
        if (err_pulse !== 1'b0) $display("FAIL early_last_pulse_width: err=%b required 0", err_pulse); else n_pass++;
        send_beat(8'h55, 1'b1);
        n_checks++;
        if (err_pulse !== 1'b1 || level !== l0)
            $display("FAIL hdr_last: err=%b level=%0d required 1/%0d", err_pulse, level, l0);
        else n_pass++;
        send_record_rand(1'b1);
        n_checks++;
        if (level !== l0 + 1'b1 || err_pulse !== 1'b0)
            $display("FAIL fresh_after_err: level=%0d err=%b required %0d/0", level, err_pulse, l0 + 1'b1);
        else n_pass++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [FW-1:0] seq[6] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        int pops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = seq[i];
            in_last  = (i == 2 || i == 5);
            n_checks++;
            if (in_ready !== 1'b1) $display("FAIL b2b_ready: beat %0d in_ready=%b required 1", i, in_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (level > 1) $display("FAIL b2b_level: level=%0d required <=1", level); else n_pass++;
            if (pop_seen) begin
                pops++;
                n_checks++;
                if (!pop_exp_ok || pop_obs !== pop_exp)
                    $display("FAIL b2b_pop: out_rec=%0h required %0h", pop_obs, pop_exp);
                else n_pass++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        for (int k = 0; k < 10 && pops < 2; k++) begin
            tick();
            if (pop_seen) begin
                pops++;
                n_checks++;
                if (!pop_exp_ok || pop_obs !== pop_exp)
                    $display("FAIL b2b_pop: out_rec=%0h required %0h", pop_obs, pop_exp);
                else n_pass++;
            end
        end
        n_checks++;
        if (pops != 2) $display("FAIL b2b_count: pops=%0d required 2", pops); else n_pass++;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send_record_rand(1'b1);
        send_record_rand(1'b1);
        send_beat(FW'($urandom), 1'b0);
        send_beat(FW'($urandom), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (level !== '0 || out_valid !== 1'b0 || err_pulse !== 1'b0 || in_ready !== 1'b1)
            $display("FAIL rst_mid: level=%0d out_valid=%b err=%b in_ready=%b required 0/0/0/1",
                     level, out_valid, err_pulse, in_ready);
        else n_pass++;
        send_record_rand(1'b1);
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || exp_q.size() != 1 || out_rec !== exp_q[0])
            $display("FAIL rst_mid_fresh: out_valid=%b out_rec=%0h required 1/%0h",
                     out_valid, out_rec, (exp_q.size() > 0) ? exp_q[0] : '0);
        else n_pass++;
        drain();
    endtask

    task automatic test_missing_last();
        int e0;
        out_ready = 1'b0;
        e0 = err_count;
        send_beat(8'h7F, 1'b0);
        send_beat(8'hAA, 1'b0);
        send_beat(8'hBB, 1'b0);
        n_checks++;
        if (err_pulse !== 1'b1 || level !== 1)
            $display("FAIL no_last: err=%b level=%0d required 1/1", err_pulse, level);
        else n_pass++;
        tick();
        n_checks++;
        if (out_rec !== 24'h7FBBAA || err_count != e0 + 1)
            $display("FAIL no_last_rec: out_rec=%0h pulses=%0d required 7fbbaa/1", out_rec, err_count - e0);
        else n_pass++;
        drain();
    endtask

    task automatic test_random();
        bit want_ready;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = FW'($urandom);
            if (beats.size() == NUM_CH) in_last = ($urandom_range(0, 7) != 0);
            else                        in_last = ($urandom_range(0, 9) == 0);
            // Alternate slow and fast consumer phases to reach full and empty.
            out_ready = ((c / 100) % 2 == 0) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 3) != 0);
            want_ready = !(beats.size() == NUM_CH && exp_q.size() == DEPTH);
            n_checks++;
            if (in_ready !== want_ready) $display("FAIL rand_in_ready: cycle %0d got %b required %b", c, in_ready, want_ready);
            else n_pass++;
            tick();
            n_checks++;
            if (level !== LVL_W'(exp_q.size()) || err_pulse !== exp_err)
                $display("FAIL rand_state: cycle %0d level=%0d err=%b required %0d/%b",
                         c, level, err_pulse, exp_q.size(), exp_err);
            else n_pass++;
            if (pop_seen) begin
                n_checks++;
                if (!pop_exp_ok || pop_obs !== pop_exp)
                    $display("FAIL rand_pop: cycle %0d out_rec=%0h required %0h", c, pop_obs, pop_exp);
                else n_pass++;
            end
        end
        in_valid = 1'b0; in_last = 1'b0;
        // Flush any half-built record so the drain starts from a clean frame.
        rst = 1'b1; tick(); rst = 1'b0;
        drain();
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
        test_reset();
        test_single();
        test_full();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        test_missing_last();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_nested_record_fifo
`default_nettype wire
